// File: rtl/mul32_arbiter.sv
// mul32_arbiter: two requesters share one combinational 32x32 multiplier.
// A round-robin grant in IDLE latches the operands. The product settles for
// SETTLE_CYC cycles before it is captured into the response registers.
// The response is then held until the consumer takes it.
// Optional feature: define MUL32_ARB_ZERO_SKIP_EN to skip the settle window
// when either granted operand is zero. The result is then 0.

module mul32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mode,
  output logic [63:0] p
);
  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Extend to 64 bits so one multiply serves both modes.
  // The low 64 bits of the wide product are exact for signed and unsigned.
  always_comb begin
    a_ext = {{32{mode & a[31]}}, a};
    b_ext = {{32{mode & b[31]}}, b};
    p     = a_ext * b_ext;
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// WAIT  | operands latched, multiplier settling, cnt counting down to 0
// RESP  | result held on rsp_* until rsp_ready
module mul32_arbiter #(
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        busy
);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               id_q, id_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_hi_q, rsp_hi_d;
  logic [31:0]        rsp_lo_q, rsp_lo_d;
  logic               busy_q, busy_d;

  logic               grant;
  logic               accept;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               sel_mode;
  logic [63:0]        product;

  // Arbitration: a lone requester always wins; rr_ptr only breaks ties.
  always_comb begin
    if (req0_valid && req1_valid) grant = rr_ptr_q;
    else                          grant = req1_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !grant;
    req1_ready = (state_q == IDLE) && req1_valid &&  grant;
    accept     = req0_ready || req1_ready;
    sel_a      = grant ? req1_a    : req0_a;
    sel_b      = grant ? req1_b    : req0_b;
    sel_mode   = grant ? req1_mode : req0_mode;
  end

  // The multiplier only ever sees latched operands, never the live request buses.
  mul32 u_mul32 (
    .a    (a_q),
    .b    (b_q),
    .mode (mode_q),
    .p    (product)
  );

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = sel_a;
          b_d      = sel_b;
          mode_d   = sel_mode;
          id_d     = grant;
          rr_ptr_d = ~grant;
`ifdef MUL32_ARB_ZERO_SKIP_EN
          if ((sel_a == 32'd0) || (sel_b == 32'd0)) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant;
            rsp_hi_d    = 32'd0;
            rsp_lo_d    = 32'd0;
            state_d     = RESP;
          end else begin
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
            state_d = WAIT;
          end
`else
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          state_d = WAIT;
`endif
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_hi_d    = product[63:32];
          rsp_lo_d    = product[31:0];
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      id_q        <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_hi_q    <= 32'd0;
      rsp_lo_q    <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_lo_q    <= rsp_lo_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul32_arbiter.sv
// Directed bench for mul32_arbiter: products, latency, backpressure,
// reset mid-operation, round-robin fairness and the zero-operand case.
module tb_mul32_arbiter;
  localparam int SETTLE_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_mode;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_mode;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_hi, rsp_lo;

  int n_cmp = 0;
  int n_bad = 0;

  mul32_arbiter #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_hi     (rsp_hi),
    .rsp_lo     (rsp_lo),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Issues one op from an idle DUT with rsp_ready high. Starts and ends just after a negedge.
  // lat = rising edges after the accept edge until rsp_valid is observed.
  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic m, output logic got_id, output logic [31:0] hi,
                       output logic [31:0] lo, output int lat, output bit timeout);
    int n;
    timeout = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = m;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = m;
    end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) timeout = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    if (lat >= 20) timeout = 1'b1;
    got_id = rsp_id;
    hi     = rsp_hi;
    lo     = rsp_lo;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({rsp_valid, rsp_id, busy, req0_ready, req1_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {rsp_valid, rsp_id, busy, req0_ready, req1_ready});
    end
    n_cmp++;
    if ({rsp_hi, rsp_lo} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_data got=%h exp=0", {rsp_hi, rsp_lo});
    end
  endtask

  task automatic test_unsigned;
    logic id; logic [31:0] hi, lo; int lat; bit to;
    do_op(1'b0, 32'd292, 32'd6785, 1'b0, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL t1_timeout got=%0d exp=0", to); end
    n_cmp++;
    if ({id, hi, lo} !== {1'b0, 32'd0, 32'd1981220}) begin
      n_bad++;
      $display("FAIL t1_result got=%0d/%h/%h exp=0/0/%h", id, hi, lo, 32'd1981220);
    end
    n_cmp++;
    if (lat !== SETTLE_CYC) begin n_bad++; $display("FAIL t1_latency got=%0d exp=%0d", lat, SETTLE_CYC); end
  endtask

  task automatic test_signed;
    logic id; logic [31:0] hi, lo; int lat; bit to;
    do_op(1'b1, 32'hFFFFFFFD, 32'd7, 1'b1, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0 || {id, hi, lo} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB}) begin
      n_bad++;
      $display("FAIL t2_signed got=%0d/%h/%h to=%0d exp=1/ffffffff/ffffffeb", id, hi, lo, to);
    end
    // Second op from req1 alone: granted even though rr_ptr now favours req0.
    do_op(1'b1, 32'd5, 32'd6, 1'b0, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0 || {id, hi, lo} !== {1'b1, 32'd0, 32'd30}) begin
      n_bad++;
      $display("FAIL t2_single_req got=%0d/%h/%h to=%0d exp=1/0/1e", id, hi, lo, to);
    end
  endtask

  task automatic test_extremes;
    logic id; logic [31:0] hi, lo; int lat; bit to;
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0 || {hi, lo} !== 64'hFFFFFFFE_00000001) begin
      n_bad++;
      $display("FAIL t3_unsigned_max got=%h%h to=%0d exp=fffffffe00000001", hi, lo, to);
    end
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0 || {hi, lo} !== 64'h00000000_00000001) begin
      n_bad++;
      $display("FAIL t3_signed_minus1 got=%h%h to=%0d exp=0000000000000001", hi, lo, to);
    end
    do_op(1'b0, 32'h80000000, 32'h80000000, 1'b1, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0 || {hi, lo} !== 64'h40000000_00000000) begin
      n_bad++;
      $display("FAIL t3_signed_minint got=%h%h to=%0d exp=4000000000000000", hi, lo, to);
    end
  endtask

  task automatic test_zero;
    logic id; logic [31:0] hi, lo; int lat; bit to; int exp_lat;
`ifdef MUL32_ARB_ZERO_SKIP_EN
    exp_lat = 0;   // response registered on the accept edge itself
`else
    exp_lat = SETTLE_CYC;
`endif
    do_op(1'b0, 32'd0, 32'd5, 1'b0, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0 || {hi, lo} !== 64'd0 || id !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_zero_a got=%0d/%h%h to=%0d exp=0/0", id, hi, lo, to);
    end
    n_cmp++;
    if (lat !== exp_lat) begin n_bad++; $display("FAIL t6_latency got=%0d exp=%0d", lat, exp_lat); end
    do_op(1'b1, 32'hFFFFFFFF, 32'd0, 1'b1, id, hi, lo, lat, to);
    n_cmp++;
    if (to !== 1'b0 || {hi, lo} !== 64'd0 || id !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_zero_b got=%0d/%h%h to=%0d exp=1/0", id, hi, lo, to);
    end
  endtask

  task automatic test_backpressure;
    int n; bit unstable; bit rdy_seen;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd11; req0_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    n_cmp++;
    if (rsp_valid !== 1'b1 || {rsp_id, rsp_hi, rsp_lo} !== {1'b0, 32'd0, 32'd110}) begin
      n_bad++;
      $display("FAIL t5_bp_result got=%0d/%0d/%h/%h exp=1/0/0/6e", rsp_valid, rsp_id, rsp_hi, rsp_lo);
    end
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3; req1_mode = 1'b0;
    unstable = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_hi, rsp_lo} !== {1'b0, 32'd0, 32'd110} || busy !== 1'b1)
        unstable = 1'b1;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) rdy_seen = 1'b1;
    end
    n_cmp++;
    if (unstable !== 1'b0) begin n_bad++; $display("FAIL t5_rsp_stable got=%0d exp=0", unstable); end
    n_cmp++;
    if (rdy_seen !== 1'b0) begin n_bad++; $display("FAIL t5_no_accept_in_resp got=%0d exp=0", rdy_seen); end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL t5_release got=%b exp=00", {rsp_valid, busy});
    end
  endtask

  task automatic test_reset_mid_op;
    bit spurious;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL t5_in_wait got=%0d exp=1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, busy, rsp_hi, rsp_lo} !== 67'd0) begin
      n_bad++;
      $display("FAIL t5_rst_outputs got=%0d/%0d/%0d/%h/%h exp=all0", rsp_valid, rsp_id, busy, rsp_hi, rsp_lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious !== 1'b0) begin n_bad++; $display("FAIL t5_rst_no_rsp got=%0d exp=0", spurious); end
    // rr_ptr was 1 before reset; after reset a tie must go to req0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL t5_rr_ptr_reset got=%b exp=10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_fairness;
    int seen; logic ids[4]; logic [31:0] los[4]; int times[4]; bit overlap;
    seen = 0;
    overlap = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd5; req1_mode = 1'b0;
    for (int cyc = 0; cyc < 60 && seen < 4; cyc++) begin
      @(negedge clk); #1;
      if (busy && (req0_ready || req1_ready)) overlap = 1'b1;
      if (req0_ready && req1_ready) overlap = 1'b1;
      if (rsp_valid === 1'b1) begin
        ids[seen] = rsp_id; los[seen] = rsp_lo; times[seen] = cyc; seen++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (seen !== 4) begin
      n_bad++;
      $display("FAIL t4_rsp_count got=%0d exp=4", seen);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ids[i] !== 1'(i % 2) || los[i] !== ((i % 2 == 1) ? 32'd20 : 32'd6)) begin
          n_bad++;
          $display("FAIL t4_order[%0d] got=id%0d lo%0d exp=id%0d lo%0d", i, ids[i], los[i],
                   i % 2, (i % 2 == 1) ? 20 : 6);
        end
      end
      n_cmp++;
      if (times[1] - times[0] !== SETTLE_CYC + 2) begin
        n_bad++;
        $display("FAIL t4_issue_interval got=%0d exp=%0d", times[1] - times[0], SETTLE_CYC + 2);
      end
    end
    n_cmp++;
    if (overlap !== 1'b0) begin n_bad++; $display("FAIL t4_ready_when_busy got=%0d exp=0", overlap); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_mode = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_unsigned;
    test_signed;
    test_extremes;
    test_zero;
    test_backpressure;
    test_reset_mid_op;
    test_fairness;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
